// File: rtl/uart_pkg.sv
// Shared types for the configurable UART transmitter: frame-format enums,
// FSM state encoding and decoders for the CPU-side configuration codes.
package uart_pkg;

  localparam int unsigned MIN_DBIT = 5;

  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_e;
  typedef enum logic [1:0] {STOP_1, STOP_1P5, STOP_2} stop_e;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} tx_state_e;

  // Register code 11 is an alias for "no parity".
  function automatic parity_e decode_parity(input logic [1:0] code);
    parity_e result;
    case (code)
      2'b01:   result = PAR_EVEN;
      2'b10:   result = PAR_ODD;
      default: result = PAR_NONE;
    endcase
    return result;
  endfunction

  // Register code 11 is an alias for two stop bits.
  function automatic stop_e decode_stop(input logic [1:0] code);
    stop_e result;
    case (code)
      2'b00:   result = STOP_1;
      2'b01:   result = STOP_1P5;
      default: result = STOP_2;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter (5..MAX_DBIT data, none/even/odd parity,
// 1/1.5/2 stop) with valid/ready input, break generation and external baud tick.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned MAX_DBIT = 9,
  parameter int unsigned OVS      = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_tick,
  input  logic [3:0]          cfg_dbits,
  input  logic [1:0]          cfg_parity,
  input  logic [1:0]          cfg_stop,
  input  logic                send_break,
  input  logic [MAX_DBIT-1:0] din,
  input  logic                din_valid,
  output logic                din_ready,
  output logic                tx,
  output logic                busy,
  output logic                tx_done_tick
);

  localparam int unsigned TW = $clog2(2 * OVS);
  localparam int unsigned BW = $clog2(MAX_DBIT);
  localparam logic [TW-1:0] BIT_LAST = TW'(OVS - 1);

  tx_state_e            state, state_n;
  logic [TW-1:0]        tick_cnt, tick_n;
  logic [BW-1:0]        bit_cnt, bit_n;
  logic [MAX_DBIT-1:0]  shreg, shreg_n;
  logic                 par_acc, par_n;
  logic [3:0]           dbits_q, dbits_n;
  parity_e              parity_q, parity_n;
  stop_e                stop_q, stop_n;
  logic                 tx_n;
  logic                 done;
  logic [3:0]           dbits_clamped;
  logic [TW-1:0]        stop_last;
  logic                 accept;

  assign din_ready    = (state == IDLE) && !send_break && !reset;
  assign accept       = din_valid && din_ready;
  assign busy         = (state != IDLE);
  assign tx_done_tick = done;

  always_comb begin
    dbits_clamped = cfg_dbits;
    if (cfg_dbits < 4'(MIN_DBIT))
      dbits_clamped = 4'(MIN_DBIT);
    else if (cfg_dbits > 4'(MAX_DBIT))
      dbits_clamped = 4'(MAX_DBIT);
  end

  always_comb begin
    case (stop_q)
      STOP_1:   stop_last = TW'(OVS - 1);
      STOP_1P5: stop_last = TW'((3 * OVS) / 2 - 1);
      default:  stop_last = TW'(2 * OVS - 1);
    endcase
  end

  // tx is computed from the next state so the line moves on the state edge.
  always_comb begin
    state_n  = state;
    tick_n   = tick_cnt;
    bit_n    = bit_cnt;
    shreg_n  = shreg;
    par_n    = par_acc;
    dbits_n  = dbits_q;
    parity_n = parity_q;
    stop_n   = stop_q;
    tx_n     = tx;
    done     = 1'b0;

    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (send_break) begin
          state_n = BREAK;
          tx_n    = 1'b0;
        end else if (accept) begin
          state_n  = START;
          tx_n     = 1'b0;
          tick_n   = '0;
          bit_n    = '0;
          par_n    = 1'b0;
          shreg_n  = din;
          dbits_n  = dbits_clamped;
          parity_n = decode_parity(cfg_parity);
          stop_n   = decode_stop(cfg_stop);
        end
      end
      START: begin
        if (s_tick) begin
          if (tick_cnt == BIT_LAST) begin
            state_n = DATA;
            tick_n  = '0;
            tx_n    = shreg[0];
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (tick_cnt == BIT_LAST) begin
            tick_n = '0;
            par_n  = par_acc ^ shreg[0];
            if (bit_cnt == BW'(dbits_q - 4'd1)) begin
              if (parity_q != PAR_NONE) begin
                state_n = PARITY;
                tx_n    = par_n ^ (parity_q == PAR_ODD);
              end else begin
                state_n = STOP;
                tx_n    = 1'b1;
              end
            end else begin
              bit_n   = bit_cnt + 1'b1;
              shreg_n = shreg >> 1;
              tx_n    = shreg[1];
            end
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (tick_cnt == BIT_LAST) begin
            state_n = STOP;
            tick_n  = '0;
            tx_n    = 1'b1;
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        tx_n = 1'b1;
        if (s_tick) begin
          if (tick_cnt == stop_last) begin
            state_n = IDLE;
            tick_n  = '0;
            done    = 1'b1;
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
      end
      BREAK: begin
        tx_n = 1'b0;
        if (!send_break) begin
          state_n = IDLE;
          tx_n    = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_acc  <= 1'b0;
      dbits_q  <= 4'(MIN_DBIT);
      parity_q <= PAR_NONE;
      stop_q   <= STOP_1;
      tx       <= 1'b1;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_n;
      bit_cnt  <= bit_n;
      shreg    <= shreg_n;
      par_acc  <= par_n;
      dbits_q  <= dbits_n;
      parity_q <= parity_n;
      stop_q   <= stop_n;
      tx       <= tx_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: frame formats, cfg latching, back-to-back,
// clamping, async reset mid-frame and break generation.
module tb_uart_tx_cfg;

  logic       clk;
  logic       reset;
  logic       s_tick;
  logic [3:0] cfg_dbits;
  logic [1:0] cfg_parity;
  logic [1:0] cfg_stop;
  logic       send_break;
  logic [8:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       tx;
  logic       busy;
  logic       tx_done_tick;

  int unsigned compared;
  int unsigned mismatched;
  int          tdiv;
  int          rn;
  int          rcyc;

  uart_tx_cfg #(.MAX_DBIT(9), .OVS(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .cfg_dbits    (cfg_dbits),
    .cfg_parity   (cfg_parity),
    .cfg_stop     (cfg_stop),
    .send_break   (send_break),
    .din          (din),
    .din_valid    (din_valid),
    .din_ready    (din_ready),
    .tx           (tx),
    .busy         (busy),
    .tx_done_tick (tx_done_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // s_tick: one-cycle pulse every 4 clocks, changed 1 time unit after the edge.
  initial begin
    s_tick = 1'b0;
    tdiv   = 0;
    forever begin
      @(posedge clk);
      #1;
      s_tick = (tdiv == 3);
      tdiv   = (tdiv + 1) % 4;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // exp holds the start/data/parity levels per bit period in send order;
  // everything after is stop (high) until 'total' ticks have elapsed.
  task automatic frame(input string tag, input logic [8:0] d, input logic [3:0] db,
                       input logic [1:0] par, input logic [1:0] st, input string exp,
                       input int total, input bit keep, input logic [8:0] d_next,
                       input int chg_n, input logic [3:0] chg_db, input logic [1:0] chg_par);
    int  n;
    int  cyc;
    int  idx;
    bit  done_seen;
    logic lvl;
    n = 0;
    cyc = 0;
    done_seen = 1'b0;
    din = d;
    cfg_dbits = db;
    cfg_parity = par;
    cfg_stop = st;
    din_valid = 1'b1;
    chk({tag, "_ready_idle"}, din_ready, 1'b1);
    step();
    if (keep) din = d_next;
    else din_valid = 1'b0;
    while (!done_seen && cyc < total * 4 + 40) begin
      idx = n / 16;
      lvl = (idx < exp.len()) ? (exp.getc(idx) == 8'h31) : 1'b1;
      chk({tag, "_tx"}, tx, lvl);
      chk({tag, "_busy"}, busy, 1'b1);
      chk({tag, "_ready_busy"}, din_ready, 1'b0);
      if (s_tick && n == total - 1) begin
        chk({tag, "_done"}, tx_done_tick, 1'b1);
        done_seen = 1'b1;
      end else begin
        chk({tag, "_nodone"}, tx_done_tick, 1'b0);
      end
      if (n == chg_n) begin
        cfg_dbits = chg_db;
        cfg_parity = chg_par;
      end
      if (s_tick) n++;
      step();
      cyc++;
    end
    chk({tag, "_timeout"}, done_seen, 1'b1);
    chk({tag, "_idle_busy"}, busy, 1'b0);
    chk({tag, "_idle_tx"}, tx, 1'b1);
    chk({tag, "_idle_ready"}, din_ready, 1'b1);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    cfg_dbits  = 4'd8;
    cfg_parity = 2'b00;
    cfg_stop   = 2'b00;
    send_break = 1'b0;
    din        = '0;
    din_valid  = 1'b0;

    step();
    step();
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", tx_done_tick, 1'b0);
    chk("rst_ready", din_ready, 1'b0);
    reset = 1'b0;
    step();
    chk("post_rst_ready", din_ready, 1'b1);

    // 8N1 0xA5
    frame("t1_8n1", 9'h0A5, 4'd8, 2'b00, 2'b00, "010100101", 160, 1'b0, 9'h000, -1, 4'd0, 2'b00);
    // 7E1 / 7O1 0x35
    frame("t2_7e1", 9'h035, 4'd7, 2'b01, 2'b00, "010101100", 160, 1'b0, 9'h000, -1, 4'd0, 2'b00);
    frame("t2_7o1", 9'h035, 4'd7, 2'b10, 2'b00, "010101101", 160, 1'b0, 9'h000, -1, 4'd0, 2'b00);
    // 9O2 0x1FF, then 8N1.5 0x00
    frame("t3_9o2", 9'h1FF, 4'd9, 2'b10, 2'b10, "01111111110", 208, 1'b0, 9'h000, -1, 4'd0, 2'b00);
    frame("t3_8n15", 9'h000, 4'd8, 2'b00, 2'b01, "000000000", 168, 1'b0, 9'h000, -1, 4'd0, 2'b00);
    // back-to-back with din_valid held: 0x55 then 0xAA
    frame("t4_b2b_a", 9'h055, 4'd8, 2'b00, 2'b00, "010101010", 160, 1'b1, 9'h0AA, -1, 4'd0, 2'b00);
    frame("t4_b2b_b", 9'h0AA, 4'd8, 2'b00, 2'b00, "001010101", 160, 1'b0, 9'h000, -1, 4'd0, 2'b00);
    // cfg change mid-frame must not disturb the frame in flight
    frame("t5_latch", 9'h0C3, 4'd8, 2'b00, 2'b00, "011000011", 160, 1'b0, 9'h000, 40, 4'd5, 2'b10);
    frame("t5_5o1", 9'h013, 4'd5, 2'b10, 2'b00, "0110010", 128, 1'b0, 9'h000, -1, 4'd0, 2'b00);
    // clamping, parity code 11 = none, stop code 11 = 2 stop
    frame("clamp_lo", 9'h1FF, 4'd3, 2'b00, 2'b00, "011111", 112, 1'b0, 9'h000, -1, 4'd0, 2'b00);
    frame("clamp_hi", 9'h155, 4'd15, 2'b11, 2'b11, "0101010101", 192, 1'b0, 9'h000, -1, 4'd0, 2'b00);

    // reset in the middle of data bit 3 of 8N1 0xA5 (bit 3 is 0)
    cfg_dbits  = 4'd8;
    cfg_parity = 2'b00;
    cfg_stop   = 2'b00;
    din        = 9'h0A5;
    din_valid  = 1'b1;
    step();
    din_valid = 1'b0;
    rn   = 0;
    rcyc = 0;
    while (rn < 72 && rcyc < 1000) begin
      if (s_tick) rn++;
      step();
      rcyc++;
    end
    chk("t6_pre_tx", tx, 1'b0);
    chk("t6_pre_busy", busy, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("t6_rst_tx", tx, 1'b1);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_done", tx_done_tick, 1'b0);
    chk("t6_rst_ready", din_ready, 1'b0);
    step();
    step();
    chk("t6_rst_hold_tx", tx, 1'b1);
    reset = 1'b0;

    send_break = 1'b1;
    #1;
    chk("t6_brk_ready0", din_ready, 1'b0);
    for (int i = 0; i < 100; i++) begin
      step();
      chk("t6_brk_tx", tx, 1'b0);
      chk("t6_brk_busy", busy, 1'b1);
      chk("t6_brk_ready", din_ready, 1'b0);
      chk("t6_brk_done", tx_done_tick, 1'b0);
    end
    send_break = 1'b0;
    step();
    chk("t6_unbrk_tx", tx, 1'b1);
    chk("t6_unbrk_busy", busy, 1'b0);
    chk("t6_unbrk_done", tx_done_tick, 1'b0);
    frame("t6_8n1", 9'h00F, 4'd8, 2'b00, 2'b00, "011110000", 160, 1'b0, 9'h000, -1, 4'd0, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
